fmap_streamer: RTL and testbench
================================

FMAP_STREAMER -- requirements
Module: fmap_streamer

Interface
REQ-001 SHALL have parameter N, default 8, pixel data width.
REQ-002 SHALL have parameter INPUT_SIZE, default 6, square feature-map edge in pixels; pixel count P = INPUT_SIZE*INPUT_SIZE.
REQ-003 SHALL have parameter AW, default 10, memory address width.
REQ-004 SHALL have parameter TIMEOUT, default 1023, maximum cycles to wait for the conv end flag.
REQ-005 SHALL have ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to stream one feature map.
- base_addr  in  AW  first pixel address, sampled with start.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  AW  memory read address.
- mem_rdata  in  N  read data, valid exactly 1 cycle after mem_rd_en.
- hold  in  1  downstream pause; suppresses new reads.
- pixel_dout  out  N  pixel to the conv input.
- pixel_vld  out  1  pixel valid, active high.
- conv_end  in  1  conv operation-end flag from the downstream conv.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky timeout flag.

Function
REQ-006 SHALL implement FSM states IDLE, READ, DRAIN, WAIT_END, FINISH.
REQ-007 IDLE: start=1 SHALL latch base_addr, clear index idx and err, set busy, and go to READ next cycle; start while busy SHALL be ignored.
REQ-008 READ: each cycle with hold=0, mem_rd_en=1 and mem_addr=base+idx (modulo 2^AW wrap), idx++; with hold=1, mem_rd_en=0 and idx unchanged.
REQ-009 When the read with idx=P-1 is issued, the FSM SHALL go to DRAIN; exactly P reads SHALL be issued per start.
REQ-010 pixel_dout SHALL register mem_rdata and pixel_vld SHALL be mem_rd_en delayed 2 cycles: a read issued in cycle t yields pixel_vld=1 in cycle t+2.
REQ-011 Pixels SHALL leave in raster order (row-major, idx ascending); in-flight reads SHALL complete even when hold rises.
REQ-012 DRAIN SHALL go to WAIT_END in the cycle after the last pixel_vld.
REQ-013 WAIT_END SHALL count cycles; when conv_end=1 the FSM SHALL go to FINISH.
REQ-014 If the WAIT_END count reaches TIMEOUT with conv_end=0, err SHALL be set to 1 and the FSM SHALL go to FINISH.
REQ-015 FINISH SHALL assert done=1 for exactly one cycle, clear busy in that same cycle, and return to IDLE.
REQ-016 If start=1 in the FINISH cycle, it SHALL be ignored. A start accepted in IDLE the cycle after FINISH SHALL behave per REQ-007.
REQ-017 mem_addr SHALL hold its last value when mem_rd_en=0.
REQ-018 pixel_dout SHALL be 0 whenever pixel_vld=0.

Reset
REQ-019 rst_n=0 SHALL, asynchronously, force state IDLE, idx=0, wait count=0, and drive mem_rd_en, mem_addr, pixel_dout, pixel_vld, busy, done and err to 0.
REQ-020 Reset mid-stream SHALL discard all in-flight reads; no pixel_vld SHALL appear after rst_n rises until a new start.

Verification
REQ-021 With INPUT_SIZE=6, base=0x010, hold=0, and mem returning addr[7:0]: the bench SHALL observe 36 reads at 0x010..0x033 on consecutive cycles and 36 consecutive pixel_vld carrying 0x10..0x33, the first 2 cycles after the first read.
REQ-022 With hold=1 for cycles 5-9 of READ: the bench SHALL observe reads pausing for 5 cycles, exactly 36 pixels still emitted in order, and no duplicates.
REQ-023 With conv_end=0 during streaming, then 1 seven cycles into WAIT_END: the bench SHALL observe done pulse 1 cycle, busy falls with done, and err=0.
REQ-024 With TIMEOUT=15 and conv_end held 0: the bench SHALL observe err=1 and done after 15 WAIT_END cycles, then err cleared by the next accepted start.
REQ-025 With rst_n=0 asserted at pixel 20: the bench SHALL observe all outputs 0 immediately, then a new start streaming all 36 pixels from idx 0.
REQ-026 With base=0x3F0 and AW=10: the bench SHALL observe addresses wrap 0x3FF->0x000 and 36 reads total.

Source files
------------

// File: rtl/fmap_streamer_if.sv
// Memory read port, pixel output stream and conv end handshake of the feature-map streamer.
// The streamer owns the master side; memory, conv engine and bench own the slave side.
interface fmap_streamer_if #(
  parameter int N  = 8,
  parameter int AW = 10
);
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_rdata;
  logic          hold;
  logic [N-1:0]  pixel_dout;
  logic          pixel_vld;
  logic          conv_end;

  modport master (
    output mem_rd_en, mem_addr, pixel_dout, pixel_vld,
    input  mem_rdata, hold, conv_end
  );

  modport slave (
    input  mem_rd_en, mem_addr, pixel_dout, pixel_vld,
    output mem_rdata, hold, conv_end
  );
endinterface

// File: rtl/fmap_streamer.sv
// Streams one square feature map from memory to a conv engine in raster order,
// then waits, bounded by TIMEOUT cycles, for the conv end flag before pulsing done.
module fmap_streamer #(
  parameter int N          = 8,
  parameter int INPUT_SIZE = 6,
  parameter int AW         = 10,
  parameter int TIMEOUT    = 1023
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [AW-1:0]   base_addr,
  fmap_streamer_if.master bus,
  output logic            busy,
  output logic            done,
  output logic            err
);
  localparam int P  = INPUT_SIZE * INPUT_SIZE;
  localparam int IW = (P > 1) ? $clog2(P + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(P - 1);
  localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    DRAIN    = 3'd2,
    WAIT_END = 3'd3,
    FINISH   = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_base;
  logic [AW-1:0] r_last_addr;
  logic [IW-1:0] r_idx;
  logic [TW-1:0] r_wcnt;
  logic          r_vld1;
  logic          r_vld2;
  logic [N-1:0]  r_pix;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic          w_accept;
  logic          w_rd_en;
  logic [AW-1:0] w_rd_addr;
  logic          w_last_rd;
  logic          w_timeout;

  assign w_accept  = (r_state == IDLE) && start;
  assign w_rd_en   = (r_state == READ) && !bus.hold;
  assign w_rd_addr = r_base + AW'(r_idx);
  assign w_last_rd = w_rd_en && (r_idx == LAST_IDX);
  assign w_timeout = (r_state == WAIT_END) && !bus.conv_end && (r_wcnt == LAST_WAIT);

  // Next-state decode; DRAIN ends once no read remains in flight, so WAIT_END follows the last pixel.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_next = READ;
        else       w_next = IDLE;
      end
      READ: begin
        if (w_last_rd) w_next = DRAIN;
        else           w_next = READ;
      end
      DRAIN: begin
        if (!r_vld1) w_next = WAIT_END;
        else         w_next = DRAIN;
      end
      WAIT_END: begin
        if (bus.conv_end || w_timeout) w_next = FINISH;
        else                           w_next = WAIT_END;
      end
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State, read pointer, two-stage pixel pipeline and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_base      <= {AW{1'b0}};
      r_last_addr <= {AW{1'b0}};
      r_idx       <= {IW{1'b0}};
      r_wcnt      <= {TW{1'b0}};
      r_vld1      <= 1'b0;
      r_vld2      <= 1'b0;
      r_pix       <= {N{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == READ) || (w_next == DRAIN) || (w_next == WAIT_END);
      r_done  <= (w_next == FINISH);
      r_vld1  <= w_rd_en;
      r_vld2  <= r_vld1;
      r_pix   <= r_vld1 ? bus.mem_rdata : {N{1'b0}};
      if (w_accept) begin
        r_base <= base_addr;
        r_idx  <= {IW{1'b0}};
        r_err  <= 1'b0;
      end else if (w_rd_en) begin
        r_idx       <= r_idx + IW'(1);
        r_last_addr <= w_rd_addr;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end else begin
        r_idx <= r_idx;
      end
      if (r_state == WAIT_END) r_wcnt <= r_wcnt + TW'(1);
      else                     r_wcnt <= {TW{1'b0}};
    end
  end

  // The address bus parks on the last issued address between reads.
  assign bus.mem_rd_en  = w_rd_en;
  assign bus.mem_addr   = w_rd_en ? w_rd_addr : r_last_addr;
  assign bus.pixel_dout = r_pix;
  assign bus.pixel_vld  = r_vld2;
  assign busy           = r_busy;
  assign done           = r_done;
  assign err            = r_err;
endmodule

// File: tb/tb_fmap_streamer.sv
// Randomized bench for fmap_streamer: a timestamped transaction model predicts every output
// each cycle, and per-run literal expectations pin read counts, latencies and flags.
module tb_fmap_streamer;
  localparam int P   = 36;
  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [9:0] base_addr;
  logic       busy, done, err;

  fmap_streamer_if #(.N(8), .AW(10)) bus ();

  fmap_streamer #(.N(8), .INPUT_SIZE(6), .AW(10), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .bus(bus), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // memory returns the low address byte one cycle after a read, junk otherwise
  always @(posedge clk) bus.mem_rdata <= bus.mem_rd_en ? bus.mem_addr[7:0] : 8'($urandom);

  int n_cmp, n_bad, cyc;
  bit m_run, m_err;
  int m_rd_left, m_wait0, m_fin;
  logic [9:0] m_next, m_last;
  int pq_t[$];
  logic [7:0] pq_d[$];

  int obs_rd, obs_pix, obs_first_rd_cyc, obs_last_rd_cyc, obs_first_pix_cyc, obs_last_pix_cyc;
  int obs_done_cnt, obs_done_cyc;
  logic [9:0] obs_first_addr, obs_last_addr;
  logic [7:0] obs_first_pix, obs_last_pix;
  bit obs_wrap, obs_err_at_done, obs_busy_at_done;
  logic rm_err1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_obs();
    obs_rd = 0; obs_pix = 0; obs_done_cnt = 0; obs_wrap = 1'b0;
    obs_first_rd_cyc = 0; obs_last_rd_cyc = 0; obs_first_pix_cyc = 0; obs_last_pix_cyc = 0;
    obs_done_cyc = 0; obs_first_addr = 10'h000; obs_last_addr = 10'h000;
    obs_first_pix = 8'h00; obs_last_pix = 8'h00; obs_err_at_done = 1'b0; obs_busy_at_done = 1'b0;
  endtask

  task automatic monitor();
    logic       e_rd, e_vld, e_busy, e_done;
    logic [9:0] e_addr;
    logic [7:0] e_dout;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_run = 1'b0; m_rd_left = 0; m_last = 10'h000; m_err = 1'b0;
        m_wait0 = -1; m_fin = -1; pq_t.delete(); pq_d.delete();
      end
      e_rd   = rst_n && m_run && (m_rd_left > 0) && !bus.hold;
      e_addr = e_rd ? m_next : m_last;
      e_vld  = 1'b0;
      e_dout = 8'h00;
      if (rst_n && pq_t.size() > 0) begin
        if (pq_t[0] == cyc) begin
          e_vld  = 1'b1;
          e_dout = pq_d[0];
        end
      end
      e_busy = m_run && (cyc != m_fin);
      e_done = m_run && (cyc == m_fin);
      chk("mem_rd_en", 32'(bus.mem_rd_en), 32'(e_rd));
      chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
      chk("pixel_vld", 32'(bus.pixel_vld), 32'(e_vld));
      chk("pixel_dout", 32'(bus.pixel_dout), 32'(e_dout));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("err", 32'(err), 32'(m_err));
      // raw observations of the DUT for the per-run literal checks
      if (bus.mem_rd_en) begin
        if (obs_rd > 0 && obs_last_addr == 10'h3FF && bus.mem_addr == 10'h000) obs_wrap = 1'b1;
        if (obs_rd == 0) begin obs_first_rd_cyc = cyc; obs_first_addr = bus.mem_addr; end
        obs_rd++; obs_last_rd_cyc = cyc; obs_last_addr = bus.mem_addr;
      end
      if (bus.pixel_vld) begin
        if (obs_pix == 0) begin obs_first_pix_cyc = cyc; obs_first_pix = bus.pixel_dout; end
        obs_pix++; obs_last_pix_cyc = cyc; obs_last_pix = bus.pixel_dout;
      end
      if (done) begin
        obs_done_cnt++; obs_done_cyc = cyc; obs_err_at_done = err; obs_busy_at_done = busy;
      end
      if (rst_n) begin
        if (e_rd) begin
          pq_t.push_back(cyc + 2); pq_d.push_back(m_next[7:0]);
          m_last = m_next; m_next = m_next + 10'd1; m_rd_left--;
        end
        if (e_vld) begin
          void'(pq_t.pop_front()); void'(pq_d.pop_front());
          if (pq_t.size() == 0 && m_rd_left == 0 && m_run) m_wait0 = cyc + 1;
        end
        if (m_run && m_wait0 >= 0 && m_fin < 0 && cyc >= m_wait0) begin
          if (bus.conv_end) m_fin = cyc + 1;
          else if (cyc - m_wait0 + 1 == TMO) begin m_fin = cyc + 1; m_err = 1'b1; end
        end
        if (m_run && cyc == m_fin) m_run = 1'b0;
        else if (!m_run && start) begin
          m_run = 1'b1; m_rd_left = P; m_next = base_addr; m_err = 1'b0;
          m_wait0 = -1; m_fin = -1; clear_obs();
        end
      end
    end
  endtask

  // conv_dly > 0 raises conv_end in that WAIT_END cycle; 0 lets the timeout fire
  task automatic run_map(input logic [9:0] base, input bit hold_win, input int hold_pct,
                         input bit noise, input int conv_dly, input bit fin_start);
    int k;
    int fin_rel;
    @(posedge clk); #1;
    start = 1'b1; base_addr = base;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 10'($urandom);
    rm_err1 = err;
    k = 1;
    while (obs_pix < P && k < 400) begin
      bus.hold     = (hold_win && k >= 5 && k <= 9) || (int'($urandom_range(99)) < hold_pct);
      start        = noise && ($urandom_range(3) == 0);
      bus.conv_end = noise && ($urandom_range(3) == 0);
      @(posedge clk); #1;
      k++;
    end
    bus.hold = 1'b0; start = 1'b0; bus.conv_end = 1'b0;
    chk("pixel_wait_budget", 32'(k < 400), 32'd1);
    fin_rel = (conv_dly > 0) ? conv_dly + 1 : TMO + 1;
    for (int w = 1; w < fin_rel; w++) begin
      bus.conv_end = (w == conv_dly);
      @(posedge clk); #1;
    end
    bus.conv_end = 1'b0;
    start = fin_start;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string tag, input logic [9:0] base, input int rd_span);
    logic [9:0] last_a;
    last_a = base + 10'd35;
    chk({tag, "_reads"}, 32'(obs_rd), 32'd36);
    chk({tag, "_pixels"}, 32'(obs_pix), 32'd36);
    chk({tag, "_first_addr"}, 32'(obs_first_addr), 32'(base));
    chk({tag, "_last_addr"}, 32'(obs_last_addr), 32'(last_a));
    chk({tag, "_first_pix"}, 32'(obs_first_pix), 32'(base[7:0]));
    chk({tag, "_last_pix"}, 32'(obs_last_pix), 32'(last_a[7:0]));
    chk({tag, "_vld_latency"}, 32'(obs_first_pix_cyc - obs_first_rd_cyc), 32'd2);
    chk({tag, "_done_pulses"}, 32'(obs_done_cnt), 32'd1);
    if (rd_span >= 0) chk({tag, "_read_span"}, 32'(obs_last_rd_cyc - obs_first_rd_cyc), 32'(rd_span));
  endtask

  initial begin
    int k;
    logic [9:0] b;
    n_cmp = 0; n_bad = 0; cyc = 0;
    m_run = 1'b0; m_err = 1'b0; m_rd_left = 0; m_wait0 = -1; m_fin = -1;
    m_next = 10'h000; m_last = 10'h000; rm_err1 = 1'b0;
    clear_obs();
    rst_n = 1'b0; start = 1'b0; base_addr = 10'h000; bus.hold = 1'b0; bus.conv_end = 1'b0;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({bus.mem_rd_en, bus.mem_addr, bus.pixel_vld, bus.pixel_dout, busy, done, err}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // plain stream from 0x010, conv_end in WAIT_END cycle 7, start attempted in FINISH
    run_map(10'h010, 1'b0, 0, 1'b0, 7, 1'b1);
    check_stream("base010", 10'h010, 35);
    chk("base010_first_pix_lit", 32'(obs_first_pix), 32'h10);
    chk("base010_last_pix_lit", 32'(obs_last_pix), 32'h33);
    chk("base010_pix_span", 32'(obs_last_pix_cyc - obs_first_pix_cyc), 32'd35);
    chk("base010_done_latency", 32'(obs_done_cyc - obs_last_pix_cyc), 32'd8);
    chk("base010_busy_at_done", 32'(obs_busy_at_done), 32'd0);
    chk("base010_err_at_done", 32'(obs_err_at_done), 32'd0);

    // hold high in READ cycles 5..9
    run_map(10'h010, 1'b1, 0, 1'b0, 3, 1'b0);
    check_stream("hold", 10'h010, 40);
    chk("hold_pix_span", 32'(obs_last_pix_cyc - obs_first_pix_cyc), 32'd40);

    // conv_end never arrives
    run_map(10'h155, 1'b0, 0, 1'b0, 0, 1'b0);
    check_stream("timeout", 10'h155, 35);
    chk("timeout_err_at_done", 32'(obs_err_at_done), 32'd1);
    chk("timeout_done_latency", 32'(obs_done_cyc - obs_last_pix_cyc), 32'd16);
    chk("timeout_err_sticky", 32'(err), 32'd1);
    run_map(10'h0A0, 1'b0, 0, 1'b0, 2, 1'b0);
    chk("timeout_err_cleared", 32'(rm_err1), 32'd0);
    check_stream("after_timeout", 10'h0A0, 35);

    // asynchronous reset after pixel 20
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'h100;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (obs_pix < 20 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("reset_mid_pixels", 32'(obs_pix), 32'd20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_outputs", 32'({bus.mem_rd_en, bus.mem_addr, bus.pixel_vld, bus.pixel_dout, busy, done, err}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("reset_no_late_pixels", 32'(obs_pix), 32'd20);
    run_map(10'h200, 1'b0, 0, 1'b0, 5, 1'b0);
    check_stream("after_reset", 10'h200, 35);

    // address wrap at the top of the 10-bit space
    run_map(10'h3F0, 1'b0, 0, 1'b0, 4, 1'b0);
    check_stream("wrap", 10'h3F0, 35);
    chk("wrap_seen", 32'(obs_wrap), 32'd1);
    chk("wrap_last_addr_lit", 32'(obs_last_addr), 32'h013);
    chk("wrap_first_pix_lit", 32'(obs_first_pix), 32'hF0);

    // randomized runs: random base, random hold, start/conv_end noise while streaming
    for (int r = 0; r < 8; r++) begin
      b = 10'($urandom);
      run_map(b, 1'b0, 25, 1'b1, int'($urandom_range(14)), 1'($urandom_range(1)));
      check_stream("random", b, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
